// File: rtl/r2_w1_mem_arbiter.sv
// Two-requester front end for a 2-read/1-write memory: dedicated read ports per requester,
// round-robin arbitration of the shared write port, one-cycle registered responses.
package simple_processor_pkg;
  parameter int ADDR_WIDTH = 32;
  parameter int DATA_WIDTH = 32;
endpackage

module r2_w1_mem_arbiter #(
  parameter int ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_valid_i,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic                  a_ready_o,
  output logic                  a_rvalid_o,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  output logic                  a_err_o,
  input  logic                  b_valid_i,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  output logic                  b_ready_o,
  output logic                  b_rvalid_o,
  output logic [DATA_WIDTH-1:0] b_rdata_o,
  output logic                  b_err_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_w_addr_o,
  output logic [DATA_WIDTH-1:0] mem_w_data_o,
  output logic [ADDR_WIDTH-1:0] mem_r0_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_r0_data_i,
  output logic [ADDR_WIDTH-1:0] mem_r1_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_r1_data_i,
  output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

  logic                  r_last_grant_b;  // 1 = B won the most recent write
  logic                  r_a_rvalid, r_b_rvalid, r_a_err, r_b_err;
  logic [DATA_WIDTH-1:0] r_a_rdata, r_b_rdata;
  logic [CNT_WIDTH-1:0]  r_conflict_cnt;

  logic w_a_mis, w_b_mis, w_a_wr, w_b_wr, w_a_rd, w_b_rd;
  logic w_contend, w_grant_a, w_grant_b, w_a_acc, w_b_acc;

  assign w_a_mis = a_valid_i & (a_addr_i[1:0] != 2'b00);
  assign w_b_mis = b_valid_i & (b_addr_i[1:0] != 2'b00);
  assign w_a_wr  = a_valid_i & a_we_i & ~w_a_mis;
  assign w_b_wr  = b_valid_i & b_we_i & ~w_b_mis;
  assign w_a_rd  = a_valid_i & ~a_we_i & ~w_a_mis;
  assign w_b_rd  = b_valid_i & ~b_we_i & ~w_b_mis;

  // Under contention the requester that did not win last time gets the port.
  assign w_contend = w_a_wr & w_b_wr;
  assign w_grant_a = w_a_wr & (~w_b_wr | r_last_grant_b);
  assign w_grant_b = w_b_wr & (~w_a_wr | ~r_last_grant_b);

  assign w_a_acc   = ~rst_i & a_valid_i & (~w_a_wr | w_grant_a);
  assign w_b_acc   = ~rst_i & b_valid_i & (~w_b_wr | w_grant_b);
  assign a_ready_o = w_a_acc;
  assign b_ready_o = w_b_acc;

  assign mem_we_o     = ~rst_i & (w_grant_a | w_grant_b);
  assign mem_w_addr_o = ~mem_we_o ? '0 : (w_grant_a ? a_addr_i  : b_addr_i);
  assign mem_w_data_o = ~mem_we_o ? '0 : (w_grant_a ? a_wdata_i : b_wdata_i);

  assign mem_r0_addr_o = a_addr_i;
  assign mem_r1_addr_o = b_addr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_grant_b <= 1'b1;
      r_a_rvalid     <= 1'b0;
      r_b_rvalid     <= 1'b0;
      r_a_err        <= 1'b0;
      r_b_err        <= 1'b0;
      r_a_rdata      <= '0;
      r_b_rdata      <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_a_rvalid <= w_a_acc;
      r_b_rvalid <= w_b_acc;
      r_a_err    <= w_a_acc & w_a_mis;
      r_b_err    <= w_b_acc & w_b_mis;
      // Read data is captured at the same edge that commits any write, so it is pre-write.
      r_a_rdata  <= (w_a_acc & w_a_rd) ? mem_r0_data_i : '0;
      r_b_rdata  <= (w_b_acc & w_b_rd) ? mem_r1_data_i : '0;
      if (w_grant_a)
        r_last_grant_b <= 1'b0;
      else if (w_grant_b)
        r_last_grant_b <= 1'b1;
      if (w_contend && (r_conflict_cnt != {CNT_WIDTH{1'b1}}))
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign a_rvalid_o     = r_a_rvalid;
  assign b_rvalid_o     = r_b_rvalid;
  assign a_rdata_o      = r_a_rdata;
  assign b_rdata_o      = r_b_rdata;
  assign a_err_o        = r_a_err;
  assign b_err_o        = r_b_err;
  assign conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_r2_w1_mem_arbiter.sv
// Randomised and directed bench for r2_w1_mem_arbiter against a word-indexed reference model,
// with a small 2R/1W memory attached to the DUT's memory ports.
module tb_r2_w1_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          a_valid, a_we, b_valid, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_w_addr, mem_r0_addr, mem_r1_addr;
  logic [DW-1:0] mem_w_data, mem_r0_data, mem_r1_data;
  logic [CW-1:0] cnt;

  r2_w1_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_valid_i(a_valid), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_ready_o(a_ready), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata), .a_err_o(a_err),
    .b_valid_i(b_valid), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_ready_o(b_ready), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata), .b_err_o(b_err),
    .mem_we_o(mem_we), .mem_w_addr_o(mem_w_addr), .mem_w_data_o(mem_w_data),
    .mem_r0_addr_o(mem_r0_addr), .mem_r0_data_i(mem_r0_data),
    .mem_r1_addr_o(mem_r1_addr), .mem_r1_data_i(mem_r1_data),
    .conflict_cnt_o(cnt)
  );

  // Memory attached to the DUT: combinational reads, write commits at the edge.
  logic [DW-1:0] tb_mem [0:255];
  logic          mem_clr;
  assign mem_r0_data = tb_mem[mem_r0_addr[9:2]];
  assign mem_r1_data = tb_mem[mem_r1_addr[9:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
    end else if (mem_we) begin
      tb_mem[mem_w_addr[9:2]] <= mem_w_data;
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:256-1];
  int            m_last;      // 0 = A won last write, 1 = B
  int unsigned   m_cnt;
  bit            a_acc_last, b_acc_last, verbose;
  int            n_checks, n_errors;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // 0 idle, 1 read, 2 aligned write, 3 misaligned
  function automatic int req_class(input logic v, input logic we, input logic [AW-1:0] addr);
    if (!v) return 0;
    if (addr[1:0] != 2'b00) return 3;
    return we ? 2 : 1;
  endfunction

  // Called at a negedge with inputs applied; returns at the following negedge.
  task automatic cycle();
    int ca, cb, win;
    bit ea_rdy, eb_rdy, e_we, ea_err, eb_err;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd, ea_rd, eb_rd;
    #1;
    ca = req_class(a_valid, a_we, a_addr);
    cb = req_class(b_valid, b_we, b_addr);
    win = -1;
    if (ca == 2 && cb == 2) win = (m_last == 1) ? 0 : 1;
    else if (ca == 2) win = 0;
    else if (cb == 2) win = 1;
    if (rst) win = -1;
    ea_rdy = !rst && ca != 0 && !(ca == 2 && win != 0);
    eb_rdy = !rst && cb != 0 && !(cb == 2 && win != 1);
    e_we   = (win >= 0);
    e_wa   = (win == 0) ? a_addr : (win == 1) ? b_addr : '0;
    e_wd   = (win == 0) ? a_wdata : (win == 1) ? b_wdata : '0;
    chk("a_ready", 64'(a_ready), 64'(ea_rdy));
    chk("b_ready", 64'(b_ready), 64'(eb_rdy));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_w_addr", 64'(mem_w_addr), 64'(e_wa));
    chk("mem_w_data", 64'(mem_w_data), 64'(e_wd));
    ea_rd  = (ea_rdy && ca == 1) ? ref_mem[a_addr[9:2]] : '0;
    eb_rd  = (eb_rdy && cb == 1) ? ref_mem[b_addr[9:2]] : '0;
    ea_err = ea_rdy && ca == 3;
    eb_err = eb_rdy && cb == 3;
    if (rst) begin
      m_last = 1;
      m_cnt  = 0;
    end else begin
      if (e_we) ref_mem[e_wa[9:2]] = e_wd;
      if (win >= 0) m_last = win;
      if (ca == 2 && cb == 2 && m_cnt < 32'hFFFF) m_cnt++;
    end
    if (verbose)
      $display("TXN t=%0t rst=%0d A(v=%0d we=%0d @%0h) rdy=%0d  B(v=%0d we=%0d @%0h) rdy=%0d  wr=%0d",
               $time, rst, a_valid, a_we, a_addr, ea_rdy, b_valid, b_we, b_addr, eb_rdy, e_we);
    @(posedge clk); #1;
    chk("a_rvalid", 64'(a_rvalid), 64'(ea_rdy));
    chk("a_rdata", 64'(a_rdata), 64'(ea_rd));
    chk("a_err", 64'(a_err), 64'(ea_err));
    chk("b_rvalid", 64'(b_rvalid), 64'(eb_rdy));
    chk("b_rdata", 64'(b_rdata), 64'(eb_rd));
    chk("b_err", 64'(b_err), 64'(eb_err));
    chk("conflict_cnt", 64'(cnt), 64'(m_cnt));
    a_acc_last = ea_rdy;
    b_acc_last = eb_rdy;
    @(negedge clk);
  endtask

  task automatic set_a(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    a_valid = v; a_we = we; a_addr = ad; a_wdata = wd;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    b_valid = v; b_we = we; b_addr = ad; b_wdata = wd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; verbose = 1'b1;
    m_last = 1; m_cnt = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    rst = 1'b1; mem_clr = 1'b1;
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    mem_clr = 1'b0;

    // Requests presented during reset must not be accepted.
    set_a(1'b1, 1'b1, 32'h40, 32'h1234_5678);
    set_b(1'b1, 1'b0, 32'h44, '0);
    #1;
    chk("rst_a_ready", 64'(a_ready), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    cycle();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    cycle();
    chk("idle_cnt", 64'(cnt), 64'(0));

    // Write then read back.
    set_a(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    cycle();
    chk("wr_ack_rvalid", 64'(a_rvalid), 64'(1));
    chk("wr_ack_rdata", 64'(a_rdata), 64'(0));
    set_a(1'b1, 1'b0, 32'h40, '0);
    cycle();
    chk("rd_deadbeef", 64'(a_rdata), 64'(32'hDEAD_BEEF));
    set_a(1'b0, 1'b0, '0, '0);

    // Single contention: A first, then the stalled B.
    do_reset();
    set_a(1'b1, 1'b1, 32'h10, 32'h1111_1111);
    set_b(1'b1, 1'b1, 32'h14, 32'h2222_2222);
    #1;
    chk("c0_a_ready", 64'(a_ready), 64'(1));
    chk("c0_b_ready", 64'(b_ready), 64'(0));
    cycle();
    set_a(1'b0, 1'b0, '0, '0);
    #1;
    chk("c1_b_ready", 64'(b_ready), 64'(1));
    cycle();
    set_b(1'b0, 1'b0, '0, '0);
    chk("c_cnt_one", 64'(cnt), 64'(1));
    chk("c_mem_a", 64'(tb_mem[4]), 64'(32'h1111_1111));
    chk("c_mem_b", 64'(tb_mem[5]), 64'(32'h2222_2222));

    // Continuous contention alternates A,B,A,B.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 1'b1, 32'h20, 32'hA000_0000 + 32'(i));
      set_b(1'b1, 1'b1, 32'h24, 32'hB000_0000 + 32'(i));
      #1;
      chk("alt_a_ready", 64'(a_ready), 64'((i % 2) == 0));
      chk("alt_b_ready", 64'(b_ready), 64'((i % 2) == 1));
      cycle();
    end
    chk("alt_cnt_four", 64'(cnt), 64'(4));
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);

    // Same-word read during write returns old data, then new data.
    set_a(1'b1, 1'b1, 32'h80, 32'hAAAA_0000);
    cycle();
    set_a(1'b1, 1'b0, 32'h80, '0);
    set_b(1'b1, 1'b1, 32'h80, 32'h5555_FFFF);
    cycle();
    chk("rw_old", 64'(a_rdata), 64'(32'hAAAA_0000));
    set_b(1'b0, 1'b0, '0, '0);
    cycle();
    chk("rw_new", 64'(a_rdata), 64'(32'h5555_FFFF));

    // Misaligned write is acknowledged with an error and leaves memory untouched.
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b1, 1'b1, 32'h42, 32'hFFFF_FFFF);
    #1;
    chk("mis_b_ready", 64'(b_ready), 64'(1));
    chk("mis_mem_we", 64'(mem_we), 64'(0));
    cycle();
    chk("mis_err", 64'(b_err), 64'(1));
    chk("mis_rdata", 64'(b_rdata), 64'(0));
    set_b(1'b0, 1'b0, '0, '0);
    set_a(1'b1, 1'b0, 32'h40, '0);
    cycle();
    chk("mis_untouched", 64'(a_rdata), 64'(32'hDEAD_BEEF));
    set_a(1'b0, 1'b0, '0, '0);

    // Random traffic; a stalled requester keeps its request until accepted.
    verbose = 1'b0;
    a_acc_last = 1'b1; b_acc_last = 1'b1;
    for (int n = 0; n < 5000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!(a_valid && !a_acc_last))
        set_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              {26'd0, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0},
              $urandom);
      if (!(b_valid && !b_acc_last))
        set_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              {26'd0, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0},
              $urandom);
      cycle();
    end
    rst = 1'b0;

    // Drive the contention counter into saturation.
    do_reset();
    set_a(1'b1, 1'b1, 32'h30, 32'h0000_000A);
    set_b(1'b1, 1'b1, 32'h34, 32'h0000_000B);
    for (int n = 0; n < 65535 + 3; n++) cycle();
    chk("cnt_saturated", 64'(cnt), 64'(16'hFFFF));
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/r2_w1_mem_arbiter.md
Name: r2_w1_mem_arbiter

Overview:
Shares the 2-read/1-write 32-bit memory model between two requesters, A (core load/store unit) and B (debug/loader port). Each requester gets a dedicated read port: A uses r0 and B uses r1. The single write port is shared under round-robin arbitration. Each requester sees a valid/ready request channel and a registered one-cycle response; a contention counter is exposed for performance monitoring.

Parameters:
ADDR_WIDTH, simple_processor_pkg::ADDR_WIDTH, byte-address width
DATA_WIDTH, simple_processor_pkg::DATA_WIDTH, data width (32)
CNT_WIDTH, 16, width of the saturating write-contention counter

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_i  in  1  synchronous, active-high reset
a_valid_i / b_valid_i  in  1  request valid
a_we_i / b_we_i  in  1  1 = write, 0 = read
a_addr_i / b_addr_i  in  ADDR_WIDTH  byte address, word-aligned expected
a_wdata_i / b_wdata_i  in  DATA_WIDTH  write data
a_ready_o / b_ready_o  out  1  request accepted this cycle (valid & ready)
a_rvalid_o / b_rvalid_o  out  1  one-cycle response pulse
a_rdata_o / b_rdata_o  out  DATA_WIDTH  read data (0 for writes and errors)
a_err_o / b_err_o  out  1  misaligned request; qualified by rvalid
mem_we_o  out  1  memory write enable
mem_w_addr_o  out  ADDR_WIDTH  memory write address
mem_w_data_o  out  DATA_WIDTH  memory write data
mem_r0_addr_o  out  ADDR_WIDTH  = a_addr_i (combinational)
mem_r0_data_i  in  DATA_WIDTH  memory r0 read data (combinational)
mem_r1_addr_o  out  ADDR_WIDTH  = b_addr_i (combinational)
mem_r1_data_i  in  DATA_WIDTH  memory r1 read data (combinational)
conflict_cnt_o  out  CNT_WIDTH  count of cycles where both requesters wanted the write port

Behaviour:
- Reset (rst_i=1 at posedge):
  - all rvalid/rdata/err/conflict_cnt_o cleared to 0.
  - RR pointer last_grant set to B, so A wins the first contention.
  - While rst_i=1: ready_o=0 and mem_we_o=0 (combinationally gated).
- Request classes, per requester X:
  - read: valid & !we
  - aligned write: valid & we & addr[1:0]==0
  - misaligned: valid & addr[1:0]!=0 (read or write)
- Readiness:
  - read and misaligned requests: ready_o=1 (no shared resource used).
  - aligned write, sole writer: ready_o=1.
  - aligned write, both requesters writing (contention): grant goes to the requester that is not last_grant; loser ready_o=0. The loser must hold valid/we/addr/wdata stable until accepted.
- last_grant updates to the granted requester on every accepted aligned write, contended or not.
- Write port (combinational from the granted requester):
  - mem_we_o=1, mem_w_addr_o=addr, mem_w_data_o=wdata.
  - When no write is granted: mem_we_o=0, addr/data=0.
- Response timing, latency 1 cycle from acceptance:
  - X_rvalid_o=1 in the cycle after valid&ready.
  - read: rdata = mem_rN_data_i sampled at the accepting edge.
  - write: rdata=0, err=0.
  - misaligned: rdata=0, err=1; no memory write is issued.
  - No response backpressure; requesters must consume the pulse.
- Read/write to the same word in the same cycle (A reads, B writes, or vice versa): the read returns pre-write data, because the memory read is combinational and the write commits at the same edge. The next read returns the new data.
- Simultaneous A and B reads to the same address: both are served in the same cycle via separate ports.
- conflict_cnt_o: increments by 1 per cycle with both aligned writes pending (including stalled repeats). Saturates at all-ones; no wrap.
- Back-to-back: a requester may issue a new request every cycle; responses pipeline one per cycle.
- Reset mid-operation: any pending response is dropped (rvalid=0 next cycle); the stalled loser is not remembered.
- Address bits [ADDR_WIDTH-1:2] select the word; the block does no range checking.

Test Plan:
- Reset then idle → all ready_o=0 during reset. After reset, all rvalid=0, conflict_cnt_o=0, mem_we_o=0.
- A writes 0xDEADBEEF @0x40, next cycle A reads 0x40 → write acked (rvalid=1, rdata=0), then read rdata=0xDEADBEEF one cycle after acceptance.
- A and B write the same cycle (A: 0x11111111@0x10, B: 0x22222222@0x14), held 2 cycles:
  - cycle 0: A granted, b_ready_o=0.
  - cycle 1: B granted.
  - memory holds both values; conflict_cnt_o=1 (B's stalled repeat counts only while A also pending).
  - Repeat with both continuously writing for 4 cycles → grants alternate A,B,A,B; conflict_cnt_o=4.
- Memory preloaded 0xAAAA0000@0x80; A reads 0x80 while B writes 0x5555FFFF@0x80 in the same cycle → a_rdata_o=0xAAAA0000. A re-reads next cycle → 0x5555FFFF.
- B write to 0x42 (misaligned) → b_ready_o=1, mem_we_o=0, next cycle b_rvalid_o=1, b_err_o=1, b_rdata_o=0; word 0x40 unchanged.
- Random A/B traffic, 5000 cycles, checked against a word-indexed reference model → zero mismatches. Then force conflict_cnt_o to 0xFFFE and issue 3 contended cycles → value stays at 0xFFFF.
